// File: rtl/bin_to_bcd_pkg.sv
// bin_to_bcd_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   FSM state encoding and default width/digit counts.
package bin_to_bcd_pkg;

   localparam int DEF_WIDTH  = 12;
   localparam int DEF_DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
//   Double-dabble correction for one BCD digit: adds 3 when the digit is
//   5 or more, so the following left shift carries correctly into the next
//   decimal digit.
//   Ports:
//     din  - 4-bit scratch digit before correction
//     dout - 4-bit corrected digit
module bcd_digit_adj (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Sequential double-dabble binary-to-BCD converter. One bit is processed
//   per clock; a WIDTH-bit value takes WIDTH shift cycles plus one DONE
//   cycle, and the done pulse follows one cycle after DONE.
//   Ports:
//     clk     - clock, all state changes on the rising edge
//     rst_n   - asynchronous active-low reset
//     start   - conversion request, accepted only while idle
//     bin_in  - unsigned binary value, sampled on the accepting edge
//     busy    - high while a conversion is in progress (SHIFT or DONE)
//     done    - one-cycle pulse marking a new bcd_out
//     bcd_out - packed BCD result, digit 0 (units) in bits [3:0]
//   Legal only when 10**DIGITS > 2**WIDTH - 1.
module bin_to_bcd_seq
   import bin_to_bcd_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int CAT_W = 4*DIGITS + WIDTH;

   state_t                state;
   state_t                state_nxt;
   logic [WIDTH-1:0]      sreg;
   logic [4*DIGITS-1:0]   scratch;
   logic [4*DIGITS-1:0]   adj;
   logic [CNT_W-1:0]      cnt;
   logic [CAT_W-1:0]      shifted;

   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (scratch[4*i +: 4]),
         .dout (adj[4*i +: 4])
      );
   end

   // Corrected scratch digits and the remaining binary bits move left as one word.
   assign shifted = {adj, sreg} << 1;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         // cnt==1 means this edge performs the final shift.
         SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         bcd_out <= '0;
         scratch <= '0;
         sreg    <= '0;
         cnt     <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         // Registered from the state so the pulse lands one cycle after DONE,
         // leaving the converter already idle when the result is announced.
         done  <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  sreg    <= bin_in;
                  scratch <= '0;
                  cnt     <= CNT_W'(WIDTH);
               end
            end
            SHIFT: begin
               {scratch, sreg} <= shifted;
               cnt             <= cnt - 1'b1;
               // Publish only the final scratch so intermediates never reach the output.
               if (state_nxt == DONE)
                  bcd_out <= shifted[CAT_W-1 -: 4*DIGITS];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
//   Randomized and directed stimulus with a queue-based scoreboard. The
//   reference model computes decimal digits with division/modulo and tracks
//   acceptance with an edge-count window of WIDTH+2 edges per conversion.
module tb_bin_to_bcd_seq;

   localparam int WIDTH  = 12;
   localparam int DIGITS = 4;

   typedef struct {
      int                   k;
      int                   val;
      logic [4*DIGITS-1:0]  exp;
   } item_t;

   logic                  clk;
   logic                  rst_n;
   logic                  start;
   logic [WIDTH-1:0]      bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd_out;

   item_t                 sb[$];
   int                    edge_cnt  = 0;
   int                    next_free = 0;
   int                    vectors   = 0;
   int                    miscompares = 0;
   int                    done_seen = 0;
   logic [4*DIGITS-1:0]   model_bcd = '0;

   bin_to_bcd_seq #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bin_in  (bin_in),
      .busy    (busy),
      .done    (done),
      .bcd_out (bcd_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
      logic [4*DIGITS-1:0] r;
      int p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   // Acceptance model: a start is taken on any edge at least WIDTH+2 edges after the last one.
   always @(posedge clk) begin
      edge_cnt++;
      if (rst_n === 1'b1 && start === 1'b1 && edge_cnt >= next_free) begin
         sb.push_back('{k: edge_cnt, val: int'(bin_in), exp: ref_bcd(int'(bin_in))});
         next_free = edge_cnt + WIDTH + 2;
      end
   end

   // Monitor: compare outputs against the model every falling edge.
   always @(negedge clk) begin
      logic exp_done;
      logic exp_busy;
      if (sb.size() > 0 && edge_cnt == sb[0].k + WIDTH)
         model_bcd = sb[0].exp;
      exp_done = (sb.size() > 0) && (edge_cnt == sb[0].k + WIDTH + 1);
      exp_busy = (edge_cnt < next_free - 1);
      check("done", 32'(done), 32'(exp_done));
      check("busy", 32'(busy), 32'(exp_busy));
      check("bcd_out", 32'(bcd_out), 32'(model_bcd));
      if (done === 1'b1) begin
         done_seen++;
         for (int i = 0; i < DIGITS; i++)
            check("nibble_range", 32'(bcd_out[4*i +: 4] <= 4'd9), 32'd1);
      end
      if (exp_done) void'(sb.pop_front());
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         #1 bin_in = WIDTH'($urandom_range(0, 4095));
         n++;
      end
      check("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   task automatic convert(input int val);
      @(negedge clk);
      #1 start = 1'b1;
      bin_in = WIDTH'(val);
      @(negedge clk);
      #1 start = 1'b0;
      bin_in = WIDTH'($urandom_range(0, 4095));
      wait_idle();
   endtask

   task automatic model_reset();
      sb.delete();
      next_free = 0;
      model_bcd = '0;
   endtask

   int                    dir_val[5] = '{0, 4095, 255, 1999, 10};
   logic [15:0]           dir_exp[5] = '{16'h0000, 16'h4095, 16'h0255, 16'h1999, 16'h0010};
   int                    bnd_val[6] = '{9, 99, 999, 1000, 4094, 1};

   initial begin
      int d0;
      int v;
      rst_n  = 1'b1;
      start  = 1'b0;
      bin_in = '0;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // Directed values with literal expectations.
      for (int i = 0; i < 5; i++) begin
         convert(dir_val[i]);
         check("directed", 32'(bcd_out), 32'(dir_exp[i]));
      end

      // Start held for three cycles: only the first may be taken.
      d0 = done_seen;
      @(negedge clk);
      #1 start = 1'b1;
      bin_in = WIDTH'(7);
      repeat (3) @(negedge clk);
      #1 start = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      check("triple_start_dones", 32'(done_seen - d0), 32'd1);
      check("triple_start_value", 32'(bcd_out), 32'h0007);

      // Reset in the middle of a conversion.
      convert(1234);
      check("pre_reset_value", 32'(bcd_out), 32'h1234);
      @(negedge clk);
      #1 start = 1'b1;
      bin_in = WIDTH'(42);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      check("reset_bcd", 32'(bcd_out), 32'h0000);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      d0 = done_seen;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (WIDTH + 4) @(negedge clk);
      check("aborted_no_done", 32'(done_seen - d0), 32'd0);
      convert(42);
      check("post_reset_value", 32'(bcd_out), 32'h0042);

      // Start held high with a changing input.
      d0 = done_seen;
      @(negedge clk);
      #1 start = 1'b1;
      for (int i = 0; i < 5 * (WIDTH + 2); i++) begin
         bin_in = WIDTH'($urandom_range(0, 4095));
         @(negedge clk);
         #1;
      end
      start = 1'b0;
      wait_idle();
      check("held_start_dones", 32'(done_seen - d0), 32'd5);

      // Boundary values then a random sweep with random gaps.
      for (int i = 0; i < 126; i++) begin
         v = (i < 6) ? bnd_val[i] : int'($urandom_range(0, 4095));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         convert(v);
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #400000;
      miscompares++;
      $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
